pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Program counter and fetch sequencer for the core.
- Receives the taken/not-taken decision and the 10-bit target from the branch unit, plus halt and stall indications from decode.
- Drives the instruction-memory address.
- Runs a start/done handshake with the testbench/host and keeps a per-run cycle count.

Parameters:
- PC_W, 10, program counter width in bits (must be at least 10).
- START_ADDR, 0, PC value loaded on start.
- CNT_W, 16, width of the cycle counter.
- WDOG_LIMIT, 4096, watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  in  1  host request to begin a run; sampled in IDLE and DONE only.
- branch  in  1  branch taken (from branch unit).
- address  in  10  branch target; zero-extended to PC_W.
- halt_instr  in  1  current instruction is a halt.
- stall  in  1  freeze the PC this cycle.
- pc  out  PC_W  instruction-memory address.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE (level, not a pulse).
- cycle_count  out  CNT_W  number of RUN cycles in the current or last run.
- timeout  out  1  run ended by the watchdog.

Behaviour:
- Reset (reset=0 at the clock edge) forces the following, regardless of other inputs:
  - state=IDLE, pc=START_ADDR, cycle_count=0.
  - running=0, done=0, timeout=0.
  - A reset in the middle of a run aborts the run immediately; no done is issued.
- State IDLE:
  - pc held at START_ADDR.
  - start=1 → RUN next cycle, with pc=START_ADDR and cycle_count=0.
- State RUN: running=1. Each cycle, in priority order:
  - stall=1: pc holds; halt_instr and branch are ignored; cycle_count still increments.
  - halt_instr=1: → DONE; pc holds at the halt instruction's address.
  - branch=1: pc ← {zeros, address}.
  - otherwise: pc ← pc+1, wrapping modulo 2^PC_W (all-ones → 0, no flag).
- cycle_count in RUN:
  - Increments by 1 on every RUN cycle, including the cycle in which halt is accepted.
  - Saturates at all-ones; it does not wrap.
- State DONE:
  - done=1, running=0.
  - pc and cycle_count hold their final values.
  - start=1 → RUN with pc=START_ADDR, cycle_count=0, done=0, timeout=0 on the next cycle.
- Latency:
  - pc changes one cycle after the branch/halt/stall sample.
  - running/done change on the same edge as the state change.
- Simultaneous branch and halt: halt wins; no redirect.
- start asserted during RUN is ignored.
- Outputs are registered; no combinational path from any input to pc or done.

Optional Feature:
- Macro: PC_FETCH_WATCHDOG_EN.
- When defined:
  - If RUN reaches the cycle in which cycle_count == WDOG_LIMIT-1 without halting, the FSM enters DONE on that edge with timeout=1.
  - timeout stays 1 until the next start or reset.
  - halt on that same cycle takes priority: DONE with timeout=0.
- When undefined:
  - No watchdog logic is built.
  - timeout is tied to 0; a run without a halt runs indefinitely.

Test Plan:
- Reset then sequential run:
  - Stimulus: reset=0 for 2 cycles; release; start=1 for 1 cycle; no branch/halt for 5 cycles.
  - Response: pc sequence 0,1,2,3,4,5; running=1; cycle_count=5.
- Branch and halt:
  - Stimulus: in RUN at pc=3, branch=1 with address=132; next cycle halt_instr=1.
  - Response: pc=132 and held; done=1 and running=0 on the following cycle; cycle_count frozen.
- Stall priority:
  - Stimulus: stall=1 together with branch=1 (address=40) and halt_instr=1, pc=9.
  - Response: pc stays 9; still RUN; cycle_count+1.
  - Then stall=0 with branch=1: pc=40.
- Wrap and saturation:
  - Stimulus: START_ADDR=1022, PC_W=10; run 3 cycles.
  - Response: pc 1022,1023,0,1.
  - With CNT_W=4, run 20 cycles: cycle_count stops at 15.
- Mid-run reset and restart:
  - Stimulus: reset=0 during RUN at pc=70.
  - Response: next cycle IDLE, pc=0, cycle_count=0, done=0.
  - Then from DONE, start=1: pc=START_ADDR, done=0, count restarts at 0.
- Watchdog (macro defined, WDOG_LIMIT=8):
  - Stimulus: run with no halt.
  - Response: DONE after 8 RUN cycles, timeout=1, cycle_count=8.
  - Without the macro: still running after 8 cycles, timeout=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE run control, branch/halt/stall
// handling and a saturating per-run cycle counter. Optional watchdog: PC_FETCH_WATCHDOG_EN.
module pc_fetch #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             branch,
    input  logic [9:0]       address,
    input  logic             halt_instr,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Elaboration-time sanity check on the configuration.
    if (PC_W < 10 || WDOG_LIMIT == 0) begin : g_bad_params
        $error("pc_fetch: PC_W must be >= 10 and WDOG_LIMIT must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef PC_FETCH_WATCHDOG_EN
    logic timeout_nxt;
    logic wdog_hit;

    // Compared at 32 bits so a limit wider than the counter simply never fires.
    assign wdog_hit = (32'(cycle_count) == 32'(WDOG_LIMIT - 1));
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= START_PC;
            cycle_count <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
`ifdef PC_FETCH_WATCHDOG_EN
            timeout     <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            cycle_count <= cnt_nxt;
            running     <= (state_nxt == RUN);
            done        <= (state_nxt == DONE);
`ifdef PC_FETCH_WATCHDOG_EN
            timeout     <= timeout_nxt;
`endif
        end
    end

`ifndef PC_FETCH_WATCHDOG_EN
    assign timeout = 1'b0;
`endif

    // Next-state, next-pc and counter logic.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cycle_count;
`ifdef PC_FETCH_WATCHDOG_EN
        timeout_nxt = timeout;
`endif
        case (state)
            IDLE: begin
                pc_nxt = START_PC;
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
`ifdef PC_FETCH_WATCHDOG_EN
                    timeout_nxt = 1'b0;
`endif
                end
            end
            RUN: begin
                if (cycle_count != CNT_MAX) begin
                    cnt_nxt = cycle_count + CNT_W'(1);
                end
                // Stall beats halt beats branch.
                if (stall) begin
                    pc_nxt = pc;
                end else if (halt_instr) begin
                    state_nxt = DONE;
                end else if (branch) begin
                    pc_nxt = PC_W'(address);
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
`ifdef PC_FETCH_WATCHDOG_EN
                if (wdog_hit && state_nxt == RUN) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
`ifdef PC_FETCH_WATCHDOG_EN
                    timeout_nxt = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_PC;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expectations queued when stimulus is driven,
// popped and checked one cycle later.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        branch;
    logic [9:0]  address;
    logic        halt_instr;
    logic        stall;

    logic [9:0]  pc1;
    logic        run1, done1, to1;
    logic [15:0] cnt1;
    logic [9:0]  pc2;
    logic        run2, done2, to2;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          w;
        logic [9:0]  pc;
        logic        run;
        logic        dn;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pc_fetch #(.WDOG_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .branch(branch), .address(address),
        .halt_instr(halt_instr), .stall(stall), .pc(pc1), .running(run1), .done(done1),
        .cycle_count(cnt1), .timeout(to1)
    );

    pc_fetch #(.START_ADDR(1022), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .start(start), .branch(branch), .address(address),
        .halt_instr(halt_instr), .stall(stall), .pc(pc2), .running(run2), .done(done2),
        .cycle_count(cnt2), .timeout(to2)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic br, input logic [9:0] ad,
                         input logic hl, input logic sl);
        reset = r; start = st; branch = br; address = ad; halt_instr = hl; stall = sl;
    endtask

    task automatic expect1(input string tag, input logic [9:0] p, input logic r,
                           input logic d, input logic [15:0] c, input logic t);
        exp_t e;
        e.w = 1'b0; e.pc = p; e.run = r; e.dn = d; e.cnt = c; e.to = t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic expect2(input string tag, input logic [9:0] p, input logic r,
                           input logic [15:0] c);
        exp_t e;
        e.w = 1'b1; e.pc = p; e.run = r; e.dn = 1'b0; e.cnt = c; e.to = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance one edge, then check every queued expectation against the DUT.
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (!e.w) begin
                chk(t, "pc", 32'(pc1), 32'(e.pc));
                chk(t, "running", 32'(run1), 32'(e.run));
                chk(t, "done", 32'(done1), 32'(e.dn));
                chk(t, "count", 32'(cnt1), 32'(e.cnt));
                chk(t, "timeout", 32'(to1), 32'(e.to));
            end else begin
                chk(t, "pc_w", 32'(pc2), 32'(e.pc));
                chk(t, "running_w", 32'(run2), 32'(e.run));
                chk(t, "count_w", 32'(cnt2), 32'(e.cnt));
                chk(t, "timeout_w", 32'(to2), 32'(e.to));
            end
        end
    endtask

    initial begin
        logic [9:0]  p;
        logic [15:0] c;

        // Reset, including with start/branch asserted.
        drive(0, 0, 0, 0, 0, 0); expect1("rst", 0, 0, 0, 0, 0); expect2("rst_w", 1022, 0, 0); tick();
        drive(0, 1, 1, 5, 0, 0); expect1("rst_ovr", 0, 0, 0, 0, 0); expect2("rst_ovr_w", 1022, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); expect1("idle", 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); expect1("start", 0, 1, 0, 0, 0); tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 0, 0, 0); expect1("seq", 10'(i), 1, 0, 16'(i), 0); tick();
        end
        drive(1, 0, 0, 0, 1, 0); expect1("halt", 5, 0, 1, 6, 0); tick();
        drive(1, 0, 1, 77, 0, 0); expect1("done_hold", 5, 0, 1, 6, 0); tick();

        // Restart from DONE, branch then halt.
        drive(1, 1, 0, 0, 0, 0); expect1("restart", 0, 1, 0, 0, 0); tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, 0); expect1("seq2", 10'(i), 1, 0, 16'(i), 0); tick();
        end
        drive(1, 0, 1, 132, 0, 0); expect1("branch", 132, 1, 0, 4, 0); tick();
        drive(1, 0, 0, 0, 1, 0); expect1("halt_br", 132, 0, 1, 5, 0); tick();
        drive(1, 0, 0, 0, 0, 0); expect1("frozen", 132, 0, 1, 5, 0); tick();

        // Stall priority and branch/halt collision.
        drive(1, 1, 0, 0, 0, 0); expect1("start3", 0, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 9, 0, 0); expect1("br9", 9, 1, 0, 1, 0); tick();
        drive(1, 0, 1, 40, 1, 1); expect1("stall", 9, 1, 0, 2, 0); tick();
        drive(1, 0, 1, 40, 0, 0); expect1("br40", 40, 1, 0, 3, 0); tick();
        drive(1, 0, 1, 100, 1, 0); expect1("br_halt", 40, 0, 1, 4, 0); tick();

        // Start ignored in RUN, then mid-run reset.
        drive(1, 1, 0, 0, 0, 0); expect1("start4", 0, 1, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); expect1("start_in_run", 1, 1, 0, 1, 0); tick();
        drive(1, 0, 1, 70, 0, 0); expect1("br70", 70, 1, 0, 2, 0); tick();
        drive(0, 0, 0, 0, 0, 0); expect1("midrst", 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); expect1("idle2", 0, 0, 0, 0, 0); tick();

        // Watchdog boundary (limit 8 on dut).
        drive(1, 1, 0, 0, 0, 0); expect1("start5", 0, 1, 0, 0, 0); tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 0, 0, 0, 0);
`ifdef PC_FETCH_WATCHDOG_EN
            if (i == 8) expect1("wdog", 8, 0, 1, 8, 1);
            else        expect1("wd_run", 10'(i), 1, 0, 16'(i), 0);
`else
            expect1("wd_run", 10'(i), 1, 0, 16'(i), 0);
`endif
            tick();
        end
`ifdef PC_FETCH_WATCHDOG_EN
        drive(1, 0, 0, 0, 0, 0); expect1("wd_hold", 8, 0, 1, 8, 1); tick();
        drive(1, 1, 0, 0, 0, 0); expect1("wd_restart", 0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 0); expect1("wd_halt", 0, 0, 1, 1, 0); tick();
`else
        drive(1, 0, 0, 0, 0, 0); expect1("no_wdog", 9, 1, 0, 9, 0); tick();
        drive(1, 0, 0, 0, 1, 0); expect1("halt9", 9, 0, 1, 10, 0); tick();
`endif

        // PC wrap from 1022 and 4-bit count saturation on dut_w.
        drive(0, 0, 0, 0, 0, 0); expect2("rst_w2", 1022, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); expect2("start_w", 1022, 1, 0); tick();
        for (int k = 1; k <= 20; k++) begin
            p = 10'(1022 + k);
            c = (k > 15) ? 16'd15 : 16'(k);
            drive(1, 0, 0, 0, 0, 0); expect2("wrap", p, 1, c); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
